// File: rtl/cordic_vector.sv
// Vectoring-mode CORDIC: converts a signed (x, y) pair into raw magnitude (gain K retained)
// and a 32-bit binary angle atan2(y, x), one micro-rotation per clock behind valid/ready.
//
// state | meaning
// IDLE  | waiting for an input, in_ready high
// RUN   | performing micro-rotations 0 .. iterations-1
// DONE  | result held on magnitude/angle until out_ready
module cordic_vector #(
  parameter int width      = 16,
  parameter int iterations = 16
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [width-1:0] x_in,
  input  logic signed [width-1:0] y_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [width:0]          magnitude,
  output logic [31:0]             angle
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [4:0] LAST = 5'(iterations - 1);

  localparam logic [31:0] ATAN_LUT [16] = '{
    32'h20000000, 32'h12E4051D, 32'h09FB385B, 32'h051111D4,
    32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
    32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
    32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D
  };

  state_t state, state_next;

  logic signed [width+1:0] x, y, x_next, y_next, x_sh, y_sh, x_ext, y_ext;
  logic [31:0]             z, z_next;
  logic [4:0]              cnt;
  logic                    zero;
  logic                    last;

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (cnt == LAST) begin
          last       = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Micro-rotation: drive y toward zero, accumulating the rotated angle in z.
  always_comb begin
    x_ext = {{2{x_in[width-1]}}, x_in};
    y_ext = {{2{y_in[width-1]}}, y_in};
    x_sh  = x >>> cnt;
    y_sh  = y >>> cnt;
    if (!y[width+1]) begin
      x_next = x + y_sh;
      y_next = y - x_sh;
      z_next = z + ATAN_LUT[cnt[3:0]];
    end else begin
      x_next = x - y_sh;
      y_next = y + x_sh;
      z_next = z - ATAN_LUT[cnt[3:0]];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      x         <= '0;
      y         <= '0;
      z         <= '0;
      cnt       <= '0;
      zero      <= 1'b0;
      magnitude <= '0;
      angle     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cnt  <= '0;
            zero <= (x_in == '0) && (y_in == '0);
            // Fold left half-plane into the right half so the iterations converge.
            if (!x_in[width-1]) begin
              x <= x_ext;
              y <= y_ext;
              z <= 32'h00000000;
            end else if (!y_in[width-1]) begin
              x <= y_ext;
              y <= -x_ext;
              z <= 32'h40000000;
            end else begin
              x <= -y_ext;
              y <= x_ext;
              z <= 32'hC0000000;
            end
          end
        end
        RUN: begin
          x   <= x_next;
          y   <= y_next;
          z   <= z_next;
          cnt <= cnt + 5'd1;
          if (last) begin
            magnitude <= zero ? '0 : x_next[width:0];
            angle     <= zero ? '0 : z_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_vector.sv
// Bench for cordic_vector: directed and random vectors against a real-arithmetic atan2/hypot model,
// plus handshake, hold, back-to-back spacing and mid-conversion reset scenarios.
module tb_cordic_vector;
  localparam int W = 16;
  localparam int N = 16;
  localparam int ANG_TOL = 32'h00100000;
  // Truncating shifts bias the final x upward by a few LSB beyond the ideal K*|v|.
  localparam int MAG_TOL = 10;

  logic                clock = 1'b0;
  logic                reset_n = 1'b0;
  logic                in_valid = 1'b0;
  logic                out_ready = 1'b1;
  logic signed [W-1:0] x_in = '0;
  logic signed [W-1:0] y_in = '0;
  logic                in_ready, out_valid;
  logic [W:0]          magnitude;
  logic [31:0]         angle;

  int checks = 0;
  int errors = 0;

  cordic_vector #(.width(W), .iterations(N)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in), .out_valid(out_valid), .out_ready(out_ready),
    .magnitude(magnitude), .angle(angle)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] ref_angle(input int x, input int y);
    real    a;
    longint l;
    logic [63:0] v;
    if (x == 0 && y == 0) return 32'h0;
    a = $atan2(real'(y), real'(x)) * 2147483648.0 / 3.14159265358979323846;
    l = longint'(a);
    v = l;
    return v[31:0];
  endfunction

  function automatic int ref_mag(input int x, input int y);
    real k = 1.0;
    for (int i = 0; i < N; i++) k = k * $sqrt(1.0 + 2.0 ** (-2.0 * i));
    return int'($sqrt(real'(x) * real'(x) + real'(y) * real'(y)) * k);
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Starts and ends #1 after a rising edge; stops once out_valid is seen or the budget runs out.
  task automatic convert(input int x, input int y, output int lat,
                         output logic [W:0] m, output logic [31:0] a);
    x_in = W'(x);
    y_in = W'(y);
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clock); #1;
      lat++;
    end
    m = magnitude;
    a = angle;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (magnitude !== '0) begin errors++; $display("FAIL reset_magnitude got %0d want 0", magnitude); end
    checks++; if (angle !== '0) begin errors++; $display("FAIL reset_angle got %h want 0", angle); end
    reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_directed();
    int xs [6] = '{1000, 0, 1000, -1000, -1000, -32768};
    int ys [6] = '{0, 1000, 1000, -1000, 0, -32768};
    int lat, d;
    logic [W:0] m;
    logic [31:0] a, ea;
    for (int k = 0; k < 6; k++) begin
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL dir%0d_in_ready got %b want 1", k, in_ready); end
      convert(xs[k], ys[k], lat, m, a);
      checks++; if (lat !== N) begin errors++; $display("FAIL dir%0d_latency got %0d want %0d", k, lat, N); end
      ea = ref_angle(xs[k], ys[k]);
      d = iabs(int'(a - ea));
      checks++; if (d > ANG_TOL) begin errors++; $display("FAIL dir%0d_angle got %h want %h", k, a, ea); end
      d = iabs(int'(m) - ref_mag(xs[k], ys[k]));
      checks++; if (d > MAG_TOL) begin errors++; $display("FAIL dir%0d_magnitude got %0d want %0d", k, m, ref_mag(xs[k], ys[k])); end
      release_result();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dir%0d_drop got %b want 0", k, out_valid); end
    end
  endtask

  task automatic test_zero();
    int lat;
    logic [W:0] m;
    logic [31:0] a;
    convert(0, 0, lat, m, a);
    checks++; if (lat !== N) begin errors++; $display("FAIL zero_latency got %0d want %0d", lat, N); end
    checks++; if (m !== '0) begin errors++; $display("FAIL zero_magnitude got %0d want 0", m); end
    checks++; if (a !== 32'h0) begin errors++; $display("FAIL zero_angle got %h want 0", a); end
    release_result();
  endtask

  task automatic test_hold();
    logic [W:0] m0;
    logic [31:0] a0, ea;
    int d;
    out_ready = 1'b0;
    x_in = 16'sd3000;
    y_in = -16'sd4000;
    in_valid = 1'b1;
    @(posedge clock); #1;
    for (int c = 0; c < N; c++) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_run_in_ready cycle %0d got %b want 0", c, in_ready); end
      x_in = W'($urandom);
      y_in = W'($urandom);
      @(posedge clock); #1;
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid_rise got %b want 1", out_valid); end
    m0 = magnitude;
    a0 = angle;
    for (int c = 0; c < 20; c++) begin
      @(posedge clock); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || magnitude !== m0 || angle !== a0) begin
        errors++;
        $display("FAIL hold_stable cycle %0d got v=%b r=%b m=%0d a=%h want v=1 r=0 m=%0d a=%h",
                 c, out_valid, in_ready, magnitude, angle, m0, a0);
      end
    end
    ea = ref_angle(3000, -4000);
    d = iabs(int'(a0 - ea));
    checks++; if (d > ANG_TOL) begin errors++; $display("FAIL hold_angle got %h want %h", a0, ea); end
    d = iabs(int'(m0) - ref_mag(3000, -4000));
    checks++; if (d > MAG_TOL) begin errors++; $display("FAIL hold_magnitude got %0d want %0d", m0, ref_mag(3000, -4000)); end
    in_valid = 1'b0;
    release_result();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL hold_release got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
  endtask

  task automatic test_back_to_back();
    int acc_edges [$];
    logic acc;
    int guard;
    out_ready = 1'b1;
    x_in = 16'sd2000;
    y_in = 16'sd1500;
    in_valid = 1'b1;
    for (int e = 0; e < 60; e++) begin
      acc = in_ready;
      @(posedge clock); #1;
      if (acc) acc_edges.push_back(e);
    end
    in_valid = 1'b0;
    checks++; if (acc_edges.size() < 3) begin errors++; $display("FAIL b2b_accepts got %0d want >=3", acc_edges.size()); end
    for (int k = 1; k < acc_edges.size(); k++) begin
      checks++;
      if (acc_edges[k] - acc_edges[k-1] !== N + 2) begin
        errors++;
        $display("FAIL b2b_spacing got %0d want %0d", acc_edges[k] - acc_edges[k-1], N + 2);
      end
    end
    guard = 0;
    while (in_ready !== 1'b1 && guard < 40) begin
      @(posedge clock); #1;
      guard++;
    end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_return_idle got %b want 1", in_ready); end
  endtask

  task automatic test_reset_mid();
    int lat, d;
    logic [W:0] m;
    logic [31:0] a, ea;
    logic seen;
    x_in = 16'sd3000;
    y_in = 16'sd2000;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (5) begin @(posedge clock); #1; end
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
    checks++; if (magnitude !== '0) begin errors++; $display("FAIL midrst_magnitude got %0d want 0", magnitude); end
    checks++; if (angle !== '0) begin errors++; $display("FAIL midrst_angle got %h want 0", angle); end
    seen = 1'b0;
    repeat (20) begin
      @(posedge clock); #1;
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_no_result got %b want 0", seen); end
    convert(1000, 0, lat, m, a);
    checks++; if (lat !== N) begin errors++; $display("FAIL midrst_fresh_latency got %0d want %0d", lat, N); end
    ea = ref_angle(1000, 0);
    d = iabs(int'(a - ea));
    checks++; if (d > ANG_TOL) begin errors++; $display("FAIL midrst_fresh_angle got %h want %h", a, ea); end
    d = iabs(int'(m) - ref_mag(1000, 0));
    checks++; if (d > MAG_TOL) begin errors++; $display("FAIL midrst_fresh_magnitude got %0d want %0d", m, ref_mag(1000, 0)); end
    release_result();
  endtask

  task automatic test_random();
    int x, y, lat, d;
    logic [W:0] m;
    logic [31:0] a, ea;
    for (int k = 0; k < 24; k++) begin
      do begin
        x = int'($urandom_range(0, 65535)) - 32768;
        y = int'($urandom_range(0, 65535)) - 32768;
      end while (longint'(x) * x + longint'(y) * y < 64'd64000000);
      convert(x, y, lat, m, a);
      checks++; if (lat !== N) begin errors++; $display("FAIL rnd%0d_latency got %0d want %0d", k, lat, N); end
      ea = ref_angle(x, y);
      d = iabs(int'(a - ea));
      checks++; if (d > ANG_TOL) begin errors++; $display("FAIL rnd%0d_angle (%0d,%0d) got %h want %h", k, x, y, a, ea); end
      d = iabs(int'(m) - ref_mag(x, y));
      checks++; if (d > MAG_TOL) begin errors++; $display("FAIL rnd%0d_magnitude (%0d,%0d) got %0d want %0d", k, x, y, m, ref_mag(x, y)); end
      release_result();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_zero();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
